// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants, FSM state type and frame-length helper
package uart_pkg;
    localparam int UART_CLKS_PER_BIT = 833;
    localparam int UART_FRAME_BITS = 10;
    typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;
    function automatic int frame_clks(input int cpb, input int guard);
        return UART_FRAME_BITS * cpb + guard;
    endfunction
endpackage

// File: rtl/uart_rr_pick.sv
// uart_rr_pick: combinational round-robin picker, first valid after i_ptr, or only i_lock_id when locked
module uart_rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         i_valid,
    input  logic [$clog2(N)-1:0] i_ptr,
    input  logic                 i_lock,
    input  logic [$clog2(N)-1:0] i_lock_id,
    output logic                 o_found,
    output logic [$clog2(N)-1:0] o_idx
);
    localparam int IW = $clog2(N);
    always_comb begin : pick
        logic [IW-1:0] j;
        o_found = 1'b0;
        o_idx = '0;
        j = '0;
        for (int k = N; k >= 1; k--) begin
            j = IW'((int'(i_ptr) + k) % N);
            o_found = i_valid[j] ? 1'b1 : o_found;
            o_idx = i_valid[j] ? j : o_idx;
        end
        o_found = i_lock ? i_valid[i_lock_id] : o_found;
        o_idx = i_lock ? i_lock_id : o_idx;
    end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter among NUM_REQ requesters,
// with multi-byte packet locking and self-paced frame timing
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int GUARD_CLKS = 16,
    parameter int LOCK_TIMEOUT = 65536
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         i_req_valid,
    input  logic [8*NUM_REQ-1:0]       i_req_byte,
    input  logic [NUM_REQ-1:0]         i_req_last,
    output logic [NUM_REQ-1:0]         o_req_ack,
    output logic [7:0]                 o_tx_send,
    output logic                       o_tx_ready,
    output logic                       o_busy,
    output logic [$clog2(NUM_REQ)-1:0] o_grant_id
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int FRAME_CLKS = frame_clks(CLKS_PER_BIT, GUARD_CLKS);
    localparam int FW = $clog2(FRAME_CLKS);
    localparam int LW = $clog2(LOCK_TIMEOUT);
    state_t             r_state;
    state_t             w_next;
    logic [7:0]         r_tx_send;
    logic               r_tx_ready;
    logic [NUM_REQ-1:0] r_ack;
    logic [IW-1:0]      r_grant;
    logic [IW-1:0]      r_rr_ptr;
    logic               r_lock;
    logic [IW-1:0]      r_lock_id;
    logic [FW-1:0]      r_frame_cnt;
    logic [LW-1:0]      r_lock_cnt;
    logic               w_found;
    logic [IW-1:0]      w_idx;
    logic               w_go;
    logic               w_lock_to;
    uart_rr_pick #(.N(NUM_REQ)) u_pick (
        .i_valid  (i_req_valid),
        .i_ptr    (r_rr_ptr),
        .i_lock   (r_lock),
        .i_lock_id(r_lock_id),
        .o_found  (w_found),
        .o_idx    (w_idx)
    );
    assign w_go = (r_state == IDLE) && w_found;
    assign w_lock_to = r_lock_cnt == LW'(LOCK_TIMEOUT - 1);
    always_ff @(posedge clk) begin
        r_state <= rst ? IDLE : w_next;
    end
    always_comb begin
        w_next = (r_state == IDLE) ? (w_found ? SEND : IDLE) :
                 (r_state == SEND) ? WAIT :
                 (r_frame_cnt == '0) ? IDLE : WAIT;
    end
    // Strobe, ack and byte are registered on entry to SEND so they are visible for exactly the SEND cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_send <= '0;
            r_tx_ready <= 1'b0;
            r_ack <= '0;
            r_grant <= '0;
            r_rr_ptr <= IW'(NUM_REQ - 1);
            r_lock <= 1'b0;
            r_lock_id <= '0;
            r_frame_cnt <= '0;
            r_lock_cnt <= '0;
        end else begin
            r_tx_ready <= w_go;
            r_ack <= w_go ? NUM_REQ'(1) << w_idx : '0;
            if (w_go) begin
                r_tx_send <= i_req_byte[{w_idx, 3'b000} +: 8];
                r_grant <= w_idx;
                r_rr_ptr <= w_idx;
                r_lock <= !i_req_last[w_idx];
                r_lock_id <= w_idx;
                r_lock_cnt <= '0;
            end else if (r_state == IDLE && r_lock && !i_req_valid[r_lock_id]) begin
                r_lock <= !w_lock_to;
                r_lock_cnt <= w_lock_to ? '0 : r_lock_cnt + LW'(1);
            end
            r_frame_cnt <= (r_state == SEND) ? FW'(FRAME_CLKS - 1) :
                           (r_state == WAIT && r_frame_cnt != '0) ? r_frame_cnt - FW'(1) : r_frame_cnt;
        end
    end
    assign o_tx_send = r_tx_send;
    assign o_tx_ready = r_tx_ready;
    assign o_req_ack = r_ack;
    assign o_grant_id = r_grant;
    assign o_busy = (r_state == WAIT);
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed test of the UART TX arbiter with short frame/lock parameters
module tb_uart_tx_arbiter;
    localparam int NR = 4;
    localparam int CPB = 4;
    localparam int GUARD = 2;
    localparam int LTO = 20;
    localparam int FRAME = 10 * CPB + GUARD;
    localparam int GAP = FRAME + 2;
    logic          clk = 1'b0;
    logic          rst;
    logic [NR-1:0] req_valid;
    logic [8*NR-1:0] req_byte;
    logic [NR-1:0] req_last;
    logic [NR-1:0] req_ack;
    logic [7:0]    tx_send;
    logic          tx_ready;
    logic          busy;
    logic [1:0]    grant_id;
    int errors = 0;
    int checks = 0;
    int n;
    int cnt;
    uart_tx_arbiter #(
        .NUM_REQ(NR), .CLKS_PER_BIT(CPB), .GUARD_CLKS(GUARD), .LOCK_TIMEOUT(LTO)
    ) dut (
        .clk(clk), .rst(rst),
        .i_req_valid(req_valid), .i_req_byte(req_byte), .i_req_last(req_last),
        .o_req_ack(req_ack), .o_tx_send(tx_send), .o_tx_ready(tx_ready),
        .o_busy(busy), .o_grant_id(grant_id)
    );
    always #5 clk = ~clk;
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic wait_strobe(input string tag, output int cycles);
        cycles = 0;
        do begin
            tick();
            cycles++;
        end while (!tx_ready && cycles < 200);
        check({tag, "_strobe_seen"}, 32'(tx_ready), 32'd1);
    endtask
    task automatic check_reset(input string tag);
        check({tag, "_ready"}, 32'(tx_ready), 32'd0);
        check({tag, "_ack"}, 32'(req_ack), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_send"}, 32'(tx_send), 32'd0);
        check({tag, "_grant"}, 32'(grant_id), 32'd0);
    endtask
    initial begin
        rst = 1'b1;
        req_valid = '0;
        req_byte = '0;
        req_last = '0;
        tick();
        tick();
        check_reset("reset");
        // single byte from requester 0
        rst = 1'b0;
        req_valid = 4'b0001;
        req_byte[7:0] = 8'hC9;
        req_last = 4'b1111;
        tick();
        check("single_ready", 32'(tx_ready), 32'd1);
        check("single_send", 32'(tx_send), 32'hC9);
        check("single_ack", 32'(req_ack), 32'b0001);
        check("single_grant", 32'(grant_id), 32'd0);
        req_valid = '0;
        tick();
        check("single_ready_pulse", 32'(tx_ready), 32'd0);
        check("single_ack_pulse", 32'(req_ack), 32'd0);
        n = busy ? 1 : 0;
        while (busy && n < 100) begin
            tick();
            if (busy) n++;
        end
        check("single_busy_len", 32'(n), 32'(FRAME));
        // round robin among four held requesters
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req_valid = 4'b1111;
        req_byte = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        for (int i = 0; i < 5; i++) begin
            wait_strobe("rr", n);
            check("rr_ack", 32'(req_ack), 32'd1 << (i % 4));
            check("rr_send", 32'(tx_send), 32'hA0 + 32'(i % 4));
            check("rr_spacing", 32'(n), (i == 0) ? 32'd1 : 32'(GAP));
        end
        // packet lock on requester 2 while requester 0 waits
        rst = 1'b1;
        req_valid = '0;
        tick();
        rst = 1'b0;
        req_valid = 4'b0100;
        req_byte[23:16] = 8'h11;
        req_last = 4'b1011;
        wait_strobe("lock1", n);
        check("lock1_ack", 32'(req_ack), 32'b0100);
        check("lock1_send", 32'(tx_send), 32'h11);
        check("lock1_grant", 32'(grant_id), 32'd2);
        req_byte[23:16] = 8'h22;
        req_byte[7:0] = 8'h55;
        req_valid = 4'b0101;
        wait_strobe("lock2", n);
        check("lock2_gap", 32'(n), 32'(GAP));
        check("lock2_ack", 32'(req_ack), 32'b0100);
        check("lock2_send", 32'(tx_send), 32'h22);
        req_byte[23:16] = 8'h33;
        req_last = 4'b1111;
        wait_strobe("lock3", n);
        check("lock3_ack", 32'(req_ack), 32'b0100);
        check("lock3_send", 32'(tx_send), 32'h33);
        req_valid = 4'b0001;
        wait_strobe("lock4", n);
        check("lock4_gap", 32'(n), 32'(GAP));
        check("lock4_ack", 32'(req_ack), 32'b0001);
        check("lock4_send", 32'(tx_send), 32'h55);
        check("lock4_grant", 32'(grant_id), 32'd0);
        // lock timeout: requester 1 locks then goes silent, requester 3 waits
        rst = 1'b1;
        req_valid = '0;
        tick();
        rst = 1'b0;
        req_valid = 4'b0010;
        req_byte[15:8] = 8'h77;
        req_last = 4'b1101;
        wait_strobe("to1", n);
        check("to1_ack", 32'(req_ack), 32'b0010);
        req_valid = 4'b1000;
        req_byte[31:24] = 8'h99;
        req_last = 4'b1111;
        wait_strobe("to2", n);
        check("to2_gap", 32'(n), 32'(1 + FRAME + LTO + 1));
        check("to2_ack", 32'(req_ack), 32'b1000);
        check("to2_send", 32'(tx_send), 32'h99);
        check("to2_grant", 32'(grant_id), 32'd3);
        // reset in the middle of a frame with requester 0 still pending
        req_valid = 4'b0001;
        req_byte[7:0] = 8'h5A;
        wait_strobe("mid", n);
        check("mid_gap", 32'(n), 32'(GAP));
        check("mid_ack", 32'(req_ack), 32'b0001);
        repeat (10) tick();
        check("mid_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        check_reset("midrst");
        rst = 1'b0;
        tick();
        check("midrst_ready", 32'(tx_ready), 32'd1);
        check("midrst_ack", 32'(req_ack), 32'b0001);
        check("midrst_send", 32'(tx_send), 32'h5A);
        req_valid = '0;
        // a request withdrawn during WAIT is never served
        repeat (5) tick();
        req_valid = 4'b0010;
        tick();
        req_valid = '0;
        cnt = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (tx_ready || req_ack != '0) cnt++;
        end
        check("glitch_no_strobe", 32'(cnt), 32'd0);
        check("glitch_idle", 32'(busy), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single transmitter of `uart_simple` between `NUM_REQ` on-chip requesters using round-robin arbitration with optional multi-byte packet locking. It sits between the requesters and the `tx_send`/`tx_ready` inputs of `uart_simple`. `uart_simple` exposes no transmit-busy flag, so the block paces bytes itself with a frame-length counter. Default rate is 38400 baud from the 32 MHz clock.

## Interface
- `NUM_REQ`, 4: number of requesters (2..8).
- `CLKS_PER_BIT`, 833: clocks per UART bit (32 MHz / 38400).
- `GUARD_CLKS`, 16: extra idle clocks appended after each frame.
- `LOCK_TIMEOUT`, 65536: clocks a packet lock is held while the locked requester has no valid byte.
- `clk` in 1: system clock, one clock domain.
- `rst` in 1: synchronous reset, active-high.
- `req_valid` in NUM_REQ: requester i has a byte pending.
- `req_byte` in 8*NUM_REQ: byte for requester i in bits [8i+7:8i].
- `req_last` in NUM_REQ: byte is the last of its packet (1 = release lock).
- `req_ack` out NUM_REQ: one-cycle pulse, byte of requester i accepted.
- `tx_send` out 8: byte to `uart_simple`; held stable from strobe until next strobe.
- `tx_ready` out 1: one-cycle start strobe to `uart_simple`.
- `busy` out 1: frame in flight (state WAIT).
- `grant_id` out clog2(NUM_REQ): requester of the last accepted byte.

## Operation
- FRAME_CLKS = 10*CLKS_PER_BIT + GUARD_CLKS (1 start, 8 data, 1 stop bit). Default value is 8346.
- State IDLE:
  - With no lock, selects the first valid requester searching from `rr_ptr+1` modulo NUM_REQ.
  - With a lock, considers only the locked requester `lock_id`.
  - On selection it moves to SEND.
- State SEND (one cycle):
  - Registers `tx_send` with the selected byte.
  - Asserts `tx_ready`=1 and `req_ack[g]`=1.
  - Sets `grant_id`=g and `rr_ptr`=g.
  - If `req_last[g]`=0, sets lock=1 and `lock_id`=g. Otherwise clears lock.
  - Loads `frame_cnt`=FRAME_CLKS-1 and moves to WAIT.
- State WAIT: `busy`=1 and `frame_cnt` decrements each cycle. At 0 the block returns to IDLE.
- Requester contract:
  - Hold `req_valid`/`req_byte`/`req_last` stable until `req_ack`.
  - Present the next byte or drop `req_valid` in the cycle after `req_ack`.
- Lock timeout:
  - In IDLE with lock=1 and `req_valid[lock_id]`=0, `lock_cnt` increments.
  - When `lock_cnt` reaches LOCK_TIMEOUT-1, lock clears and normal round-robin resumes the next cycle.
  - `lock_cnt` clears on every SEND.
- Reset values: state IDLE, `tx_ready`=0, `req_ack`=0, `busy`=0, `tx_send`=0, `grant_id`=0, lock=0, counters 0, `rr_ptr`=NUM_REQ-1 (requester 0 wins first).

## Timing
- Latency from `req_valid` rising in IDLE to `tx_ready`/`req_ack` is 1 cycle, registered.
- Minimum strobe-to-strobe spacing is FRAME_CLKS+2 cycles: SEND, WAIT×FRAME_CLKS, IDLE×1.
- Requests arriving during SEND/WAIT are ignored until IDLE. `req_valid` dropping before ack withdraws the request with no error.
- Simultaneous valids: the lowest index at or after `rr_ptr+1` wins, with wrap-around from NUM_REQ-1 to 0.
- If `rst` is asserted mid-frame, all state clears the next edge. `uart_simple` shares `rst`, so the in-flight frame aborts, and no `req_ack` is re-issued for it.
- `tx_ready` is never asserted in two consecutive cycles.

## Structure
- Package `uart_pkg`:
  - `UART_CLKS_PER_BIT`=833.
  - `UART_FRAME_BITS`=10.
  - State enum {IDLE, SEND, WAIT}.
- Sub-module `uart_rr_pick`: combinational round-robin priority picker with inputs `valid`, `ptr`, `lock`, `lock_id` and outputs `found`, `idx`. It is reusable for the planned RX dispatcher.

## Test plan
- Reset, then `req_valid`=4'b0001 with byte 0xC9 and last=1 → `tx_ready` pulse one cycle later with `tx_send`=0xC9. `uart_simple` `tx` line shows the 0xC9 frame. `busy` is high for 8346 cycles.
- `req_valid`=4'b1111, all last=1, bytes 0xA0..0xA3 held → acks in order 0,1,2,3,0 with strobes exactly 8348 cycles apart.
- Requester 2 sends 3-byte packet 0x11,0x22,0x33 (last on the third byte) while requester 0 stays valid → requester 0 is not acked until after 0x33. Then `grant_id`=0.
- Lock held by requester 1 with `req_valid[1]`=0 for 65536 IDLE cycles while requester 3 is valid → requester 3 is acked one cycle after the timeout.
- `rst` pulsed 1000 cycles into WAIT → all outputs return to reset values the next cycle. Requester 0 (pending) is strobed 1 cycle after `rst` deasserts.
- `req_valid` asserted and dropped for one cycle during WAIT → no ack and no strobe.
